// File: rtl/usb_event_queue.sv
// USB HID event queue: key FIFO with overflow flag, saturating mouse delta
// accumulators and a maskable level interrupt, all behind an 8-bit register bus.
module usb_event_queue #(
    parameter int DEPTH = 8
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       key_valid_i,
    input  logic [7:0] key_char_i,
    input  logic [7:0] key_mod_i,
    input  logic       mouse_valid_i,
    input  logic [7:0] mouse_btn_i,
    input  logic [7:0] mouse_dx_i,
    input  logic [7:0] mouse_dy_i,
    input  logic       cs_i,
    input  logic       wr_n_i,
    input  logic [7:0] reg_addr_i,
    input  logic [7:0] data_i,
    output logic [7:0] data_o,
    output logic       irq_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    // Event inputs are single-cycle valid pulses with no back-pressure; the
    // bus strobe cs_i marks exactly one cycle per access, so read side
    // effects fire once per access.
    logic [15:0]   mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [AW:0]   count, count_next;
    logic          ovf, ovf_next;
    logic          key_ie, key_ie_next, mouse_ie, mouse_ie_next;
    logic          mouse_pend, mouse_pend_next;
    logic [7:0]    btn, btn_next, acc_dx, acc_dx_next, acc_dy, acc_dy_next;

    logic rd_en, wr_en, empty, full, pop, push, flush, drop;
    logic rd_btn, rd_dx, rd_dy;

    function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [7:0] b);
        logic signed [8:0] s;
        s = $signed({a[7], a}) + $signed({b[7], b});
        if (s > 9'sd127)
            sat_add = 8'h7F;
        else if (s < -9'sd128)
            sat_add = 8'h80;
        else
            sat_add = s[7:0];
    endfunction

    assign rd_en  = cs_i & wr_n_i;
    assign wr_en  = cs_i & ~wr_n_i;
    assign empty  = (count == '0);
    assign full   = (count == FULL_COUNT);
    assign pop    = rd_en & (reg_addr_i == 8'h01) & ~empty;
    assign flush  = wr_en & (reg_addr_i == 8'h06) & data_i[7];
    assign push   = key_valid_i & ~flush & (~full | pop);
    assign drop   = key_valid_i & ~flush & full & ~pop;
    assign rd_btn = rd_en & (reg_addr_i == 8'h03);
    assign rd_dx  = rd_en & (reg_addr_i == 8'h04);
    assign rd_dy  = rd_en & (reg_addr_i == 8'h05);

    always_comb begin
        count_next      = count;
        ovf_next        = ovf;
        key_ie_next     = key_ie;
        mouse_ie_next   = mouse_ie;
        btn_next        = btn;
        acc_dx_next     = acc_dx;
        acc_dy_next     = acc_dy;
        mouse_pend_next = mouse_pend;

        if (flush)
            count_next = '0;
        else
            count_next = count + (AW + 1)'(push) - (AW + 1)'(pop);

        if (wr_en && reg_addr_i == 8'h00 && data_i[3])
            ovf_next = 1'b0;
        if (drop)
            ovf_next = 1'b1;

        if (wr_en && reg_addr_i == 8'h06) begin
            key_ie_next   = data_i[0];
            mouse_ie_next = data_i[1];
        end

        // A read-clear coincident with a new report keeps only the new report.
        if (rd_btn)
            mouse_pend_next = 1'b0;
        if (rd_dx)
            acc_dx_next = 8'h00;
        if (rd_dy)
            acc_dy_next = 8'h00;
        if (mouse_valid_i) begin
            btn_next        = mouse_btn_i;
            mouse_pend_next = 1'b1;
            acc_dx_next     = rd_dx ? mouse_dx_i : sat_add(acc_dx, mouse_dx_i);
            acc_dy_next     = rd_dy ? mouse_dy_i : sat_add(acc_dy, mouse_dy_i);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            ovf        <= 1'b0;
            key_ie     <= 1'b0;
            mouse_ie   <= 1'b0;
            btn        <= 8'h00;
            acc_dx     <= 8'h00;
            acc_dy     <= 8'h00;
            mouse_pend <= 1'b0;
            irq_o      <= 1'b0;
        end else begin
            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (pop)
                    rd_ptr <= rd_ptr + 1'b1;
                if (push)
                    wr_ptr <= wr_ptr + 1'b1;
            end
            count      <= count_next;
            ovf        <= ovf_next;
            key_ie     <= key_ie_next;
            mouse_ie   <= mouse_ie_next;
            btn        <= btn_next;
            acc_dx     <= acc_dx_next;
            acc_dy     <= acc_dy_next;
            mouse_pend <= mouse_pend_next;
            irq_o      <= (key_ie_next & (count_next != '0)) | (mouse_ie_next & mouse_pend_next);
        end
    end

    // Storage is not reset; only entries behind the pointers are ever read.
    always_ff @(posedge clk_i) begin
        if (push)
            mem[wr_ptr] <= {key_mod_i, key_char_i};
    end

    always_comb begin
        data_o = 8'h00;
        case (reg_addr_i)
            8'h00: data_o = {4'b0, ovf, mouse_pend, full, ~empty};
            8'h01: data_o = empty ? 8'h00 : mem[rd_ptr][7:0];
            8'h02: data_o = empty ? 8'h00 : mem[rd_ptr][15:8];
            8'h03: data_o = btn;
            8'h04: data_o = acc_dx;
            8'h05: data_o = acc_dy;
            8'h06: data_o = {6'b0, mouse_ie, key_ie};
            default: data_o = 8'h00;
        endcase
    end
endmodule

// File: tb/tb_usb_event_queue.sv
// Directed bench for usb_event_queue: FIFO ordering, overflow, full push+pop,
// mouse saturation, interrupt masking, flush and asynchronous reset.
module tb_usb_event_queue;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_valid = 1'b0;
    logic [7:0] key_char = 8'h00;
    logic [7:0] key_mod = 8'h00;
    logic       mouse_valid = 1'b0;
    logic [7:0] mouse_btn = 8'h00;
    logic [7:0] mouse_dx = 8'h00;
    logic [7:0] mouse_dy = 8'h00;
    logic       cs = 1'b0;
    logic       wr_n = 1'b1;
    logic [7:0] reg_addr = 8'h00;
    logic [7:0] wdata = 8'h00;
    logic [7:0] rdata;
    logic       irq;

    int checks = 0;
    int passed = 0;

    usb_event_queue #(.DEPTH(8)) dut (
        .clk_i(clk), .rst_i(rst),
        .key_valid_i(key_valid), .key_char_i(key_char), .key_mod_i(key_mod),
        .mouse_valid_i(mouse_valid), .mouse_btn_i(mouse_btn),
        .mouse_dx_i(mouse_dx), .mouse_dy_i(mouse_dy),
        .cs_i(cs), .wr_n_i(wr_n), .reg_addr_i(reg_addr), .data_i(wdata),
        .data_o(rdata), .irq_o(irq)
    );

    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    task automatic push_key(input logic [7:0] c, input logic [7:0] m);
        @(negedge clk);
        key_valid = 1'b1; key_char = c; key_mod = m;
        @(posedge clk); #1;
        key_valid = 1'b0;
    endtask

    task automatic mouse_report(input logic [7:0] b, input logic [7:0] dx, input logic [7:0] dy);
        @(negedge clk);
        mouse_valid = 1'b1; mouse_btn = b; mouse_dx = dx; mouse_dy = dy;
        @(posedge clk); #1;
        mouse_valid = 1'b0;
    endtask

    task automatic bus_read(input logic [7:0] a, output logic [7:0] d);
        @(negedge clk);
        cs = 1'b1; wr_n = 1'b1; reg_addr = a;
        #1 d = rdata;
        @(posedge clk); #1;
        cs = 1'b0;
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        cs = 1'b1; wr_n = 1'b0; reg_addr = a; wdata = d;
        @(posedge clk); #1;
        cs = 1'b0; wr_n = 1'b1;
    endtask

    task automatic peek(input logic [7:0] a, output logic [7:0] d);
        @(negedge clk);
        cs = 1'b0; reg_addr = a;
        #1 d = rdata;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [7:0] d;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (irq !== 1'b0) $display("FAIL reset_irq got %b want 0", irq); else passed++;
        @(negedge clk); rst = 1'b0;
        peek(8'h00, d);
        checks++; if (d !== 8'h00) $display("FAIL reset_status got %h want 00", d); else passed++;
        peek(8'h06, d);
        checks++; if (d !== 8'h00) $display("FAIL reset_ctrl got %h want 00", d); else passed++;
    endtask

    task automatic test_basic();
        logic [7:0] d;
        logic [7:0] addrs [6] = '{8'h02, 8'h01, 8'h02, 8'h01, 8'h00, 8'h01};
        logic [7:0] exps  [6] = '{8'h00, 8'h61, 8'h02, 8'h42, 8'h00, 8'h00};
        push_key(8'h61, 8'h00);
        push_key(8'h42, 8'h02);
        for (int i = 0; i < 6; i++) begin
            bus_read(addrs[i], d);
            checks++;
            if (d !== exps[i]) $display("FAIL basic_read%0d addr %h got %h want %h", i, addrs[i], d, exps[i]);
            else passed++;
        end
    endtask

    task automatic test_overflow();
        logic [7:0] d;
        for (int i = 0; i < 9; i++) push_key(8'h30 + 8'(i), 8'h00);
        peek(8'h00, d);
        checks++; if (d !== 8'h0B) $display("FAIL ovf_status got %h want 0B", d); else passed++;
        for (int i = 0; i < 8; i++) begin
            bus_read(8'h01, d);
            checks++;
            if (d !== 8'h30 + 8'(i)) $display("FAIL ovf_order%0d got %h want %h", i, d, 8'h30 + 8'(i));
            else passed++;
        end
        peek(8'h00, d);
        checks++; if (d !== 8'h08) $display("FAIL ovf_sticky got %h want 08", d); else passed++;
        bus_write(8'h00, 8'h08);
        peek(8'h00, d);
        checks++; if (d !== 8'h00) $display("FAIL ovf_clear got %h want 00", d); else passed++;
    endtask

    task automatic test_full_pop();
        logic [7:0] d;
        for (int i = 0; i < 8; i++) push_key(8'h40 + 8'(i), 8'h00);
        @(negedge clk);
        key_valid = 1'b1; key_char = 8'h50; key_mod = 8'h00;
        cs = 1'b1; wr_n = 1'b1; reg_addr = 8'h01;
        #1 d = rdata;
        @(posedge clk); #1;
        key_valid = 1'b0; cs = 1'b0;
        checks++; if (d !== 8'h40) $display("FAIL fullpop_head got %h want 40", d); else passed++;
        peek(8'h00, d);
        checks++; if (d !== 8'h03) $display("FAIL fullpop_status got %h want 03", d); else passed++;
        for (int i = 1; i < 8; i++) bus_read(8'h01, d);
        checks++; if (d !== 8'h47) $display("FAIL fullpop_seventh got %h want 47", d); else passed++;
        bus_read(8'h01, d);
        checks++; if (d !== 8'h50) $display("FAIL fullpop_tail got %h want 50", d); else passed++;
        peek(8'h00, d);
        checks++; if (d !== 8'h00) $display("FAIL fullpop_empty got %h want 00", d); else passed++;
    endtask

    task automatic test_mouse();
        logic [7:0] d;
        mouse_report(8'h01, 8'd100, 8'hFD);
        mouse_report(8'h05, 8'd100, 8'h00);
        peek(8'h00, d);
        checks++; if (d !== 8'h04) $display("FAIL mouse_pend got %h want 04", d); else passed++;
        bus_read(8'h04, d);
        checks++; if (d !== 8'h7F) $display("FAIL mouse_sat_pos got %h want 7F", d); else passed++;
        bus_read(8'h04, d);
        checks++; if (d !== 8'h00) $display("FAIL mouse_dx_clear got %h want 00", d); else passed++;
        bus_read(8'h05, d);
        checks++; if (d !== 8'hFD) $display("FAIL mouse_dy got %h want FD", d); else passed++;
        mouse_report(8'h05, 8'h9C, 8'h00);
        mouse_report(8'h05, 8'h9C, 8'h00);
        bus_read(8'h04, d);
        checks++; if (d !== 8'h80) $display("FAIL mouse_sat_neg got %h want 80", d); else passed++;
        @(negedge clk);
        mouse_valid = 1'b1; mouse_btn = 8'h02; mouse_dx = 8'd5; mouse_dy = 8'h00;
        cs = 1'b1; wr_n = 1'b1; reg_addr = 8'h04;
        #1 d = rdata;
        @(posedge clk); #1;
        mouse_valid = 1'b0; cs = 1'b0;
        checks++; if (d !== 8'h00) $display("FAIL mouse_coinc_old got %h want 00", d); else passed++;
        bus_read(8'h04, d);
        checks++; if (d !== 8'h05) $display("FAIL mouse_coinc_new got %h want 05", d); else passed++;
        bus_read(8'h03, d);
        checks++; if (d !== 8'h02) $display("FAIL mouse_btn got %h want 02", d); else passed++;
        peek(8'h00, d);
        checks++; if (d !== 8'h00) $display("FAIL mouse_pend_clear got %h want 00", d); else passed++;
    endtask

    task automatic test_irq();
        logic [7:0] d;
        bus_write(8'h06, 8'h01);
        checks++; if (irq !== 1'b0) $display("FAIL irq_idle got %b want 0", irq); else passed++;
        push_key(8'h31, 8'h00);
        checks++; if (irq !== 1'b1) $display("FAIL irq_key_set got %b want 1", irq); else passed++;
        bus_read(8'h06, d);
        checks++; if (d !== 8'h01) $display("FAIL irq_ctrl_rd got %h want 01", d); else passed++;
        bus_read(8'h01, d);
        checks++; if (irq !== 1'b0) $display("FAIL irq_key_drain got %b want 0", irq); else passed++;
        bus_write(8'h06, 8'h00);
        push_key(8'h32, 8'h00);
        checks++; if (irq !== 1'b0) $display("FAIL irq_masked got %b want 0", irq); else passed++;
        bus_read(8'h01, d);
        checks++; if (d !== 8'h32) $display("FAIL irq_masked_key got %h want 32", d); else passed++;
        bus_write(8'h06, 8'h02);
        mouse_report(8'h01, 8'h00, 8'h00);
        checks++; if (irq !== 1'b1) $display("FAIL irq_mouse_set got %b want 1", irq); else passed++;
        bus_read(8'h03, d);
        checks++; if (irq !== 1'b0) $display("FAIL irq_mouse_drain got %b want 0", irq); else passed++;
        bus_write(8'h06, 8'h00);
    endtask

    task automatic test_flush();
        logic [7:0] d;
        bus_write(8'h06, 8'h01);
        for (int i = 0; i < 3; i++) push_key(8'h60 + 8'(i), 8'h00);
        checks++; if (irq !== 1'b1) $display("FAIL flush_pre_irq got %b want 1", irq); else passed++;
        bus_write(8'h06, 8'h80);
        peek(8'h00, d);
        checks++; if (d !== 8'h00) $display("FAIL flush_status got %h want 00", d); else passed++;
        checks++; if (irq !== 1'b0) $display("FAIL flush_irq got %b want 0", irq); else passed++;
        peek(8'h06, d);
        checks++; if (d !== 8'h00) $display("FAIL flush_ctrl got %h want 00", d); else passed++;
        // key arriving in the same cycle as a flush is discarded
        push_key(8'h70, 8'h00);
        @(negedge clk);
        key_valid = 1'b1; key_char = 8'h77;
        cs = 1'b1; wr_n = 1'b0; reg_addr = 8'h06; wdata = 8'h80;
        @(posedge clk); #1;
        key_valid = 1'b0; cs = 1'b0; wr_n = 1'b1;
        peek(8'h00, d);
        checks++; if (d !== 8'h00) $display("FAIL flush_coinc got %h want 00", d); else passed++;
    endtask

    task automatic test_reset_mid();
        logic [7:0] d;
        bus_write(8'h06, 8'h03);
        for (int i = 0; i < 9; i++) push_key(8'h20 + 8'(i), 8'h00);
        mouse_report(8'h07, 8'd10, 8'd20);
        @(negedge clk); #2;
        rst = 1'b1;
        #1;
        checks++; if (irq !== 1'b0) $display("FAIL rstmid_irq got %b want 0", irq); else passed++;
        for (int a = 0; a < 7; a++) begin
            reg_addr = 8'(a);
            #1;
            checks++;
            if (rdata !== 8'h00) $display("FAIL rstmid_reg%0d got %h want 00", a, rdata);
            else passed++;
        end
        @(negedge clk); rst = 1'b0;
        push_key(8'h55, 8'h11);
        peek(8'h00, d);
        checks++; if (d !== 8'h01) $display("FAIL rstmid_push_status got %h want 01", d); else passed++;
        bus_read(8'h02, d);
        checks++; if (d !== 8'h11) $display("FAIL rstmid_push_mod got %h want 11", d); else passed++;
        bus_read(8'h01, d);
        checks++; if (d !== 8'h55) $display("FAIL rstmid_push_char got %h want 55", d); else passed++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_full_pop();
        test_mouse();
        test_irq();
        test_flush();
        test_reset_mid();
        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running want finished");
        $fatal(1, "timeout");
    end
endmodule
